// File: rtl/multi_cycle_ctrl_pkg.sv
// rtl/multi_cycle_ctrl_pkg.sv - state, class, opcode, SignOp and ALUOp encodings for the LEGv8 control
package multi_cycle_ctrl_pkg;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_BRANCH = 3'd5;
  localparam logic [2:0] ST_TRAP   = 3'd6;

  typedef enum logic [2:0] {
    CLS_NONE, CLS_R, CLS_I, CLS_D, CLS_B, CLS_CB, CLS_ILLEGAL
  } instr_class_e;

  localparam logic [10:0] OP_LDUR    = 11'b11111000010;
  localparam logic [10:0] OP_STUR    = 11'b11111000000;
  localparam logic [10:0] OP_ADD     = 11'b10001011000;
  localparam logic [10:0] OP_SUB     = 11'b11001011000;
  localparam logic [10:0] OP_AND     = 11'b10001010000;
  localparam logic [10:0] OP_ORR     = 11'b10101010000;
  localparam logic [9:0]  OP_ADDI_HI = 10'b1001000100;
  localparam logic [5:0]  OP_B_HI    = 6'b000101;
  localparam logic [7:0]  OP_CBZ_HI  = 8'b10110100;

  localparam logic [1:0] SE_I  = 2'b00;
  localparam logic [1:0] SE_D  = 2'b01;
  localparam logic [1:0] SE_B  = 2'b10;
  localparam logic [1:0] SE_CB = 2'b11;

  localparam logic [3:0] ALU_ADD    = 4'b0010;
  localparam logic [3:0] ALU_SUB    = 4'b0110;
  localparam logic [3:0] ALU_AND    = 4'b0000;
  localparam logic [3:0] ALU_ORR    = 4'b0001;
  localparam logic [3:0] ALU_PASS_B = 4'b0111;

  // R and ILLEGAL have no immediate field; leave the extender in I mode
  function automatic logic [1:0] class_to_signop(input instr_class_e cls);
    case (cls)
      CLS_D:   return SE_D;
      CLS_B:   return SE_B;
      CLS_CB:  return SE_CB;
      default: return SE_I;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// rtl/multi_cycle_ctrl_if.sv - instruction handshake and datapath control bundle
interface multi_cycle_ctrl_if #(parameter int CNT_W = 32);
  logic             imem_valid;
  logic [10:0]      Opcode;
  logic             Zero;
  logic             IRWrite;
  logic [1:0]       SignOp;
  logic             Reg2Loc;
  logic             ALUSrc;
  logic [3:0]       ALUOp;
  logic             MemRead;
  logic             MemWrite;
  logic             MemToReg;
  logic             RegWrite;
  logic             PCWrite;
  logic             PCSel;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  imem_valid, Opcode, Zero,
    output IRWrite, SignOp, Reg2Loc, ALUSrc, ALUOp, MemRead, MemWrite,
           MemToReg, RegWrite, PCWrite, PCSel, illegal, retired
  );

  modport slave (
    output imem_valid, Opcode, Zero,
    input  IRWrite, SignOp, Reg2Loc, ALUSrc, ALUOp, MemRead, MemWrite,
           MemToReg, RegWrite, PCWrite, PCSel, illegal, retired
  );
endinterface

// File: rtl/multi_cycle_ctrl_opcode_class_dec.sv
// rtl/multi_cycle_ctrl_opcode_class_dec.sv - combinational opcode classifier shared with single-cycle control
module opcode_class_dec
  import multi_cycle_ctrl_pkg::*;
(
  input  logic [10:0]  opcode,
  output instr_class_e cls,
  output logic [1:0]   sign_op,
  output logic [3:0]   alu_op,
  output logic         is_store
);

  always_comb begin
    cls      = CLS_ILLEGAL;
    alu_op   = ALU_ADD;
    is_store = 1'b0;
    if (opcode == OP_LDUR) begin
      cls = CLS_D;
    end else if (opcode == OP_STUR) begin
      cls      = CLS_D;
      is_store = 1'b1;
    end else if (opcode == OP_ADD) begin
      cls = CLS_R;
    end else if (opcode == OP_SUB) begin
      cls    = CLS_R;
      alu_op = ALU_SUB;
    end else if (opcode == OP_AND) begin
      cls    = CLS_R;
      alu_op = ALU_AND;
    end else if (opcode == OP_ORR) begin
      cls    = CLS_R;
      alu_op = ALU_ORR;
    end else if (opcode[10:1] == OP_ADDI_HI) begin
      cls = CLS_I;
    end else if (opcode[10:5] == OP_B_HI) begin
      cls = CLS_B;
    end else if (opcode[10:3] == OP_CBZ_HI) begin
      cls    = CLS_CB;
      alu_op = ALU_PASS_B;
    end
  end

  assign sign_op = class_to_signop(cls);

endmodule

// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - multi-cycle LEGv8 control FSM; PERF_CNT_EN adds the retired-instruction counter
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 32
) (
  input  logic               CLK,
  input  logic               Reset_L,
  multi_cycle_ctrl_if.master bus
);

  localparam logic [3:0] MEM_LAT_C = 4'(MEM_LAT);

  logic [2:0]   state;
  instr_class_e cls_q;
  logic [3:0]   alu_q;
  logic         store_q;
  logic         taken_q;
  logic [1:0]   sign_pend_q;
  logic [1:0]   sign_q;
  logic [3:0]   mem_cnt;

  instr_class_e dec_cls;
  logic [1:0]   dec_sign;
  logic [3:0]   dec_alu;
  logic         dec_store;

  logic ir_write, reg2loc, alu_src, mem_read, mem_write, mem_to_reg, reg_write, pc_write, pc_sel;
  logic [3:0] alu_op;

  opcode_class_dec u_dec (
    .opcode   (bus.Opcode),
    .cls      (dec_cls),
    .sign_op  (dec_sign),
    .alu_op   (dec_alu),
    .is_store (dec_store)
  );

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state       <= ST_FETCH;
      cls_q       <= CLS_NONE;
      alu_q       <= ALU_ADD;
      store_q     <= 1'b0;
      taken_q     <= 1'b0;
      sign_pend_q <= SE_I;
      sign_q      <= SE_I;
      mem_cnt     <= 4'd0;
    end else begin
      case (state)
        ST_FETCH: if (bus.imem_valid) begin
          cls_q       <= dec_cls;
          alu_q       <= dec_alu;
          store_q     <= dec_store;
          sign_pend_q <= dec_sign;
          state       <= ST_DECODE;
        end
        ST_DECODE: begin
          sign_q <= sign_pend_q;
          case (cls_q)
            CLS_B:                 state <= ST_BRANCH;
            CLS_ILLEGAL, CLS_NONE: state <= ST_TRAP;
            default:               state <= ST_EXEC;
          endcase
        end
        ST_EXEC: begin
          if (cls_q == CLS_CB) taken_q <= bus.Zero;
          case (cls_q)
            CLS_D: begin
              state   <= ST_MEM;
              mem_cnt <= MEM_LAT_C;
            end
            CLS_CB:  state <= ST_BRANCH;
            default: state <= ST_WB;
          endcase
        end
        // fixed-latency memory: count down, never exit early
        ST_MEM: begin
          if (mem_cnt == 4'd1) state <= store_q ? ST_FETCH : ST_WB;
          else                 mem_cnt <= mem_cnt - 4'd1;
        end
        ST_WB, ST_BRANCH: state <= ST_FETCH;
        ST_TRAP:          state <= ST_TRAP;
        default:          state <= ST_FETCH;
      endcase
    end
  end

  always_comb begin
    ir_write   = 1'b0;
    reg2loc    = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_AND;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    pc_write   = 1'b0;
    pc_sel     = 1'b0;
    case (state)
      ST_FETCH: ir_write = bus.imem_valid & Reset_L;
      ST_EXEC: begin
        alu_src = (cls_q == CLS_I) || (cls_q == CLS_D);
        alu_op  = alu_q;
        reg2loc = (cls_q == CLS_CB) || ((cls_q == CLS_D) && store_q);
      end
      ST_MEM: begin
        mem_read  = !store_q;
        mem_write = store_q;
        reg2loc   = store_q;
        pc_write  = store_q && (mem_cnt == 4'd1);
      end
      ST_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls_q == CLS_D);
        pc_write   = 1'b1;
      end
      ST_BRANCH: begin
        pc_write = 1'b1;
        pc_sel   = (cls_q == CLS_B) ? 1'b1 : taken_q;
      end
      default: ;
    endcase
  end

  // SignOp is live during DECODE so the extender settles before EXEC, then held
  assign bus.SignOp   = (state == ST_DECODE) ? sign_pend_q : sign_q;
  assign bus.IRWrite  = ir_write;
  assign bus.Reg2Loc  = reg2loc;
  assign bus.ALUSrc   = alu_src;
  assign bus.ALUOp    = alu_op;
  assign bus.MemRead  = mem_read;
  assign bus.MemWrite = mem_write;
  assign bus.MemToReg = mem_to_reg;
  assign bus.RegWrite = reg_write;
  assign bus.PCWrite  = pc_write;
  assign bus.PCSel    = pc_sel;
  assign bus.illegal  = (state == ST_TRAP);

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] retired_q;
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L)      retired_q <= '0;
    else if (pc_write) retired_q <= retired_q + CNT_W'(1);
  end
  assign bus.retired = retired_q;
`else
  assign bus.retired = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb/tb_multi_cycle_ctrl.sv - directed self-checking bench for multi_cycle_ctrl
module tb_multi_cycle_ctrl;

  logic CLK = 1'b0;
  logic Reset_L;
  always #5 CLK = ~CLK;

  multi_cycle_ctrl_if #(.CNT_W(32)) bus();

  multi_cycle_ctrl #(.MEM_LAT(2), .CNT_W(32)) dut (
    .CLK     (CLK),
    .Reset_L (Reset_L),
    .bus     (bus.master)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int lat, n_irw, n_mr, n_mw, n_rw, n_m2r, n_conf;
  logic       pcsel_s;
  logic [1:0] so_s;
  logic [3:0] ex_aluop;
  logic       ex_alusrc, ex_r2l;

  logic [10:0] ri_op    [5] = '{11'b10001011000, 11'b11001011000, 11'b10001010000,
                                11'b10101010000, 11'b10010001000};
  logic [3:0]  ri_aluop [5] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0010};
  logic        ri_src   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] strobes();
    return {bus.IRWrite, bus.Reg2Loc, bus.ALUSrc, bus.MemRead, bus.MemWrite,
            bus.MemToReg, bus.RegWrite, bus.PCWrite, bus.PCSel};
  endfunction

  // Called just after a rising edge with the FSM in FETCH; returns just after
  // the edge that ends the PCWrite cycle (or after max_cyc cycles).
  task automatic run_instr(input logic [10:0] op, input logic zero, input int max_cyc);
    int  idx  = 0;
    bit  done = 0;
    lat = 0; n_irw = 0; n_mr = 0; n_mw = 0; n_rw = 0; n_m2r = 0; n_conf = 0;
    pcsel_s = 1'bx; so_s = 2'bxx; ex_aluop = 4'bxxxx; ex_alusrc = 1'bx; ex_r2l = 1'bx;
    bus.imem_valid = 1'b1;
    bus.Opcode     = op;
    bus.Zero       = ~zero;
    for (int c = 0; c < max_cyc && !done; c++) begin
      @(negedge CLK);
      if (bus.IRWrite) begin
        n_irw++;
        idx = 1;
      end else if (idx > 0) begin
        idx++;
      end
      if (idx == 3) begin
        ex_aluop  = bus.ALUOp;
        ex_alusrc = bus.ALUSrc;
        ex_r2l    = bus.Reg2Loc;
      end
      n_mr  += int'(bus.MemRead);
      n_mw  += int'(bus.MemWrite);
      n_rw  += int'(bus.RegWrite);
      n_m2r += int'(bus.MemToReg);
      if (int'(bus.MemRead) + int'(bus.MemWrite) + int'(bus.RegWrite) > 1) n_conf++;
      if (bus.PCWrite) begin
        lat     = idx;
        pcsel_s = bus.PCSel;
        so_s    = bus.SignOp;
        done    = 1;
      end
      @(posedge CLK);
      #1;
      if (idx >= 1) begin
        bus.imem_valid = 1'b0;
        bus.Opcode     = 11'h000;
      end
      bus.Zero = (idx + 1 == 3) ? zero : ~zero;
    end
  endtask

  initial begin
    int   idle_ir;
    int   pcw;
    bit   found;
    logic [31:0] exp_ret;

    Reset_L        = 1'b0;
    bus.imem_valid = 1'b0;
    bus.Opcode     = 11'h000;
    bus.Zero       = 1'b0;

    repeat (2) @(negedge CLK);
    check_val("rst_strobes", 32'(strobes()), 32'h0);
    check_val("rst_signop", 32'(bus.SignOp), 32'h0);
    check_val("rst_illegal", 32'(bus.illegal), 32'h0);
    check_val("rst_retired", bus.retired, 32'h0);
    Reset_L = 1'b1;
    @(negedge CLK);
    check_val("rel_strobes", 32'(strobes()), 32'h0);
    @(posedge CLK);
    #1;

    idle_ir = 0;
    repeat (2) begin
      @(negedge CLK);
      idle_ir += int'(bus.IRWrite);
      @(posedge CLK);
      #1;
    end
    check_val("idle_irw", 32'(idle_ir), 32'd0);

    run_instr(11'b10001011000, 1'b0, 20);
    check_val("add_irw", 32'(n_irw), 32'd1);
    check_val("add_lat", 32'(lat), 32'd4);
    check_val("add_aluop", 32'(ex_aluop), 32'h2);
    check_val("add_regw", 32'(n_rw), 32'd1);
    check_val("add_memrd", 32'(n_mr), 32'd0);
    check_val("add_pcsel", 32'(pcsel_s), 32'd0);

    for (int i = 1; i < 5; i++) begin
      run_instr(ri_op[i], 1'b0, 20);
      check_val($sformatf("ri%0d_lat", i), 32'(lat), 32'd4);
      check_val($sformatf("ri%0d_aluop", i), 32'(ex_aluop), 32'(ri_aluop[i]));
      check_val($sformatf("ri%0d_alusrc", i), 32'(ex_alusrc), 32'(ri_src[i]));
      check_val($sformatf("ri%0d_signop", i), 32'(so_s), 32'h0);
      check_val($sformatf("ri%0d_regw", i), 32'(n_rw), 32'd1);
    end

`ifdef PERF_CNT_EN
    exp_ret = 32'd5;
`else
    exp_ret = 32'd0;
`endif
    check_val("retired_5", bus.retired, exp_ret);

    run_instr(11'b11111000010, 1'b0, 20);
    check_val("ldur_lat", 32'(lat), 32'd6);
    check_val("ldur_signop", 32'(so_s), 32'h1);
    check_val("ldur_memrd", 32'(n_mr), 32'd2);
    check_val("ldur_regw", 32'(n_rw), 32'd1);
    check_val("ldur_m2r", 32'(n_m2r), 32'd1);
    check_val("ldur_alusrc", 32'(ex_alusrc), 32'd1);
    check_val("ldur_conf", 32'(n_conf), 32'd0);

    run_instr(11'b11111000000, 1'b0, 20);
    check_val("stur_lat", 32'(lat), 32'd5);
    check_val("stur_memwr", 32'(n_mw), 32'd2);
    check_val("stur_regw", 32'(n_rw), 32'd0);
    check_val("stur_r2l", 32'(ex_r2l), 32'd1);
    check_val("stur_pcsel", 32'(pcsel_s), 32'd0);

    run_instr(11'b10110100101, 1'b1, 20);
    check_val("cbz1_lat", 32'(lat), 32'd4);
    check_val("cbz1_signop", 32'(so_s), 32'h3);
    check_val("cbz1_pcsel", 32'(pcsel_s), 32'd1);
    check_val("cbz1_aluop", 32'(ex_aluop), 32'h7);
    check_val("cbz1_r2l", 32'(ex_r2l), 32'd1);

    run_instr(11'b10110100010, 1'b0, 20);
    check_val("cbz0_lat", 32'(lat), 32'd4);
    check_val("cbz0_pcsel", 32'(pcsel_s), 32'd0);

    run_instr(11'b00010110011, 1'b0, 20);
    check_val("b_lat", 32'(lat), 32'd3);
    check_val("b_signop", 32'(so_s), 32'h2);
    check_val("b_pcsel", 32'(pcsel_s), 32'd1);
    check_val("b_regw", 32'(n_rw), 32'd0);

    run_instr(11'b00000000000, 1'b0, 22);
    check_val("trap_irw", 32'(n_irw), 32'd1);
    check_val("trap_nopcw", 32'(lat), 32'd0);
    check_val("trap_illegal", 32'(bus.illegal), 32'd1);
    check_val("trap_strobes", 32'(strobes()), 32'h0);
    #2;
    Reset_L = 1'b0;
    #1;
    check_val("trap_rst_illegal", 32'(bus.illegal), 32'd0);
    check_val("trap_rst_signop", 32'(bus.SignOp), 32'h0);
    @(negedge CLK);
    Reset_L = 1'b1;
    @(posedge CLK);
    #1;
    run_instr(11'b10001011000, 1'b0, 20);
    check_val("post_trap_lat", 32'(lat), 32'd4);

    found = 0;
    bus.imem_valid = 1'b1;
    bus.Opcode     = 11'b11111000000;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge CLK);
      if (bus.MemWrite) begin
        found = 1;
      end else begin
        @(posedge CLK);
        #1;
        bus.imem_valid = 1'b0;
      end
    end
    check_val("stur_mem_reached", 32'(found), 32'd1);
    #2;
    Reset_L = 1'b0;
    #1;
    check_val("mid_mem_memwr", 32'(bus.MemWrite), 32'd0);
    check_val("mid_mem_strobes", 32'(strobes()), 32'h0);
    @(negedge CLK);
    Reset_L = 1'b1;
    pcw = 0;
    repeat (6) begin
      @(negedge CLK);
      pcw += int'(bus.PCWrite);
    end
    check_val("mid_mem_nopcw", 32'(pcw), 32'd0);
    check_val("mid_mem_retired", bus.retired, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
